// File: rtl/mux_arbiter_rr_if.sv
// Handshake and data bundle between two requesters, the round-robin arbiter
// and the downstream consumer of the registered output stage.
//   req_a/data_a/ack_a : requester A (mux input 0)
//   req_b/data_b/ack_b : requester B (mux input 1)
//   sel                : mux select driven by the arbiter (0 = A, 1 = B)
//   out_valid/out_data/out_ready : single-entry output stage handshake
// Modports: slave = arbiter side, master = requesters + downstream side.
interface mux_arbiter_rr_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req_a;
    logic [DATA_W-1:0] data_a;
    logic              ack_a;
    logic              req_b;
    logic [DATA_W-1:0] data_b;
    logic              ack_b;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready,
        output ack_a, ack_b, sel, out_valid, out_data
    );

    modport master (
        output req_a, data_a, req_b, data_b, out_ready,
        input  ack_a, ack_b, sel, out_valid, out_data
    );
endinterface

// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter for a shared 32-bit 2:1 datapath mux. Grants requester
// A or B for up to MAX_BURST beats while the other side waits, drives the mux
// select, acknowledges accepted beats and registers the selected word into a
// single-entry valid/ready output stage.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mux_arbiter_rr_if.slave (requests, acks, select, output stage)
module mux_arbiter_rr #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input logic              clk,
    input logic              reset,
    mux_arbiter_rr_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StGrantA,
        StGrantB
    } state_e;

    localparam logic       LastA  = 1'b0;
    localparam logic       LastB  = 1'b1;
    localparam logic [3:0] CntMax = 4'(MAX_BURST - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic load_en;
    logic ack_a, ack_b;
    logic done_a, done_b;

    // Output stage can take a beat when empty or being drained this cycle.
    assign load_en = !out_valid_q || bus.out_ready;
    assign ack_a   = (state_q == StGrantA) && bus.req_a && load_en;
    assign ack_b   = (state_q == StGrantB) && bus.req_b && load_en;
    assign done_a  = ack_a && (cnt_q == CntMax);
    assign done_b  = ack_b && (cnt_q == CntMax);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // On a tie the side that was not served last wins.
                if (bus.req_a && (!bus.req_b || last_q == LastB)) begin
                    state_d = StGrantA;
                end else if (bus.req_b) begin
                    state_d = StGrantB;
                end
            end
            StGrantA: begin
                if (!bus.req_a || done_a) begin
                    cnt_d = '0;
                    if (bus.req_b) begin
                        state_d = StGrantB;
                        last_d  = LastA;
                    end else if (!bus.req_a) begin
                        state_d = StIdle;
                        last_d  = LastA;
                    end
                end else begin
                    cnt_d = cnt_q + {3'b000, ack_a};
                end
            end
            StGrantB: begin
                if (!bus.req_b || done_b) begin
                    cnt_d = '0;
                    if (bus.req_a) begin
                        state_d = StGrantA;
                        last_d  = LastB;
                    end else if (!bus.req_b) begin
                        state_d = StIdle;
                        last_d  = LastB;
                    end
                end else begin
                    cnt_d = cnt_q + {3'b000, ack_b};
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Select follows the grant and holds its last value through IDLE.
    always_comb begin
        sel_d = sel_q;
        if (state_d == StGrantA) begin
            sel_d = 1'b0;
        end else if (state_d == StGrantB) begin
            sel_d = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (ack_a || ack_b) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_q ? bus.data_b : bus.data_a;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= LastB;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.ack_a     = ack_a;
    assign bus.ack_b     = ack_b;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Directed bench for mux_arbiter_rr: two counting sources feed words, a
// scoreboard queue holds the expected output order, and per-cycle traces of
// ack/sel/out_valid are compared against hand-derived patterns.
module tb_mux_arbiter_rr;

    logic clk;
    logic reset;

    mux_arbiter_rr_if #(.DATA_W(32)) bus ();

    mux_arbiter_rr #(
        .DATA_W   (32),
        .MAX_BURST(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          a_left, b_left;
    logic [31:0] a_next, b_next;
    string       ack_tr, sel_tr, vld_tr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string got, input string exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s: observed %s expected %s", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req_a  = (a_left > 0);
        bus.data_a = a_next;
        bus.req_b  = (b_left > 0);
        bus.data_b = b_next;
    endtask

    task automatic clear_traces();
        ack_tr = "";
        sel_tr = "";
        vld_tr = "";
    endtask

    // One cycle: sample at the falling edge, update sources just after the rising edge.
    task automatic tick();
        logic  sa, sb;
        string c;
        @(negedge clk);
        sa = bus.ack_a;
        sb = bus.ack_b;
        c = sa ? "A" : (sb ? "B" : "-");
        ack_tr = {ack_tr, c};
        c = bus.sel ? "1" : "0";
        sel_tr = {sel_tr, c};
        c = bus.out_valid ? "1" : "0";
        vld_tr = {vld_tr, c};
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", bus.out_data, 32'hxxxx_xxxx);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (sa) begin
            a_next++;
            a_left--;
        end
        if (sb) begin
            b_next++;
            b_left--;
        end
        drive();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        chk("drained", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        a_left = 1; a_next = 32'h0000_0A00;
        b_left = 1; b_next = 32'h0000_0B00;
        drive();

        // Reset held with both requesting: everything quiet.
        repeat (2) begin
            tick();
            chk("rst_ack_a", 32'(bus.ack_a), 32'd0);
            chk("rst_ack_b", 32'(bus.ack_b), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_data", bus.out_data, 32'd0);
            chk("rst_sel", 32'(bus.sel), 32'd0);
        end
        exp_q.push_back(32'h0000_0A00);
        exp_q.push_back(32'h0000_0B00);
        reset = 1'b0;
        clear_traces();
        repeat (5) tick();
        chk_str("rst_release_ack", ack_tr, "-A-B-");
        chk_str("rst_release_sel", sel_tr, "00011");
        drain();

        // Fair sharing, both continuously requesting.
        a_left = 8; a_next = 32'h0000_0100;
        b_left = 4; b_next = 32'h0000_0200;
        drive();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0100 + 32'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0200 + 32'(i));
        for (int i = 4; i < 8; i++) exp_q.push_back(32'h0000_0100 + 32'(i));
        clear_traces();
        repeat (13) tick();
        chk_str("fair_ack", ack_tr, "-AAAABBBBAAAA");
        chk_str("fair_sel", sel_tr, "1000011110000");
        drain();

        // Single requester: latency and back-to-back beats.
        a_left = 4; a_next = 32'h0000_0011;
        drive();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0011 + 32'(i));
        clear_traces();
        repeat (7) tick();
        chk_str("single_ack", ack_tr, "-AAAA--");
        chk_str("single_valid", vld_tr, "0011110");
        drain();

        // Backpressure mid-burst in GRANT_B (last = A so B wins the tie).
        a_left = 4; a_next = 32'h0000_0400;
        b_left = 4; b_next = 32'h0000_0500;
        drive();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0500 + 32'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0400 + 32'(i));
        clear_traces();
        repeat (3) tick();
        bus.out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data", bus.out_data, 32'h0000_0501);
        end
        bus.out_ready = 1'b1;
        repeat (7) tick();
        chk_str("bp_ack", ack_tr, "-BB---BBAAAA-");
        drain();

        // Early drop in GRANT_B with A waiting.
        a_left = 2; a_next = 32'h0000_0600;
        b_left = 2; b_next = 32'h0000_0610;
        drive();
        exp_q.push_back(32'h0000_0610);
        exp_q.push_back(32'h0000_0611);
        exp_q.push_back(32'h0000_0600);
        exp_q.push_back(32'h0000_0601);
        clear_traces();
        repeat (8) tick();
        chk_str("drop_ab_ack", ack_tr, "-BB-AA--");
        chk_str("drop_ab_sel", sel_tr, "01110000");
        drain();

        // Early drop in GRANT_B with nobody waiting: IDLE, sel held at 1.
        b_left = 2; b_next = 32'h0000_0620;
        drive();
        exp_q.push_back(32'h0000_0620);
        exp_q.push_back(32'h0000_0621);
        clear_traces();
        repeat (6) tick();
        chk_str("drop_b_ack", ack_tr, "-BB---");
        chk_str("drop_b_sel", sel_tr, "011111");
        drain();

        // Reset mid-burst in GRANT_B with a beat pending.
        b_left = 4; b_next = 32'h0000_0700;
        drive();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0700 + 32'(i));
        clear_traces();
        repeat (3) tick();
        chk_str("mid_pre_ack", ack_tr, "-BB");
        chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_pre_sel", 32'(bus.sel), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sel", 32'(bus.sel), 32'd0);
        chk("mid_rst_ack_b", 32'(bus.ack_b), 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        exp_q.delete();
        b_left = 0;
        drive();
        tick();
        a_left = 1; a_next = 32'h0000_0800;
        b_left = 1; b_next = 32'h0000_0900;
        drive();
        exp_q.push_back(32'h0000_0800);
        exp_q.push_back(32'h0000_0900);
        reset = 1'b0;
        clear_traces();
        repeat (5) tick();
        chk_str("mid_after_ack", ack_tr, "-A-B-");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
